// File: rtl/picorv32_div_arb_pkg.sv
// rtl/picorv32_div_arb_pkg.sv - shared state encoding and decode constants for the PCPI divider arbiter
package picorv32_div_arb_pkg;

  localparam int         NUM_REQ       = 2;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // DIV/DIVU/REM/REMU are the M-extension ops with funct3[2] set
  function automatic logic is_divrem(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && insn[14];
  endfunction

endpackage

// File: rtl/picorv32_div_arb_pick.sv
// rtl/picorv32_div_arb_pick.sv - combinational two-way picker for the divider arbiter
// PICORV32_DIV_ARB_RR_EN selects round-robin; otherwise requester 0 wins ties.
module picorv32_div_arb_pick
  import picorv32_div_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] claim,
  input  logic               ptr,
  output logic               grant_valid,
  output logic               grant_idx,
  output logic               ptr_next
);

  assign grant_valid = |claim;

`ifdef PICORV32_DIV_ARB_RR_EN
  always_comb begin
    grant_idx = ptr;
    if (!claim[ptr]) grant_idx = ~ptr;
  end

  // After a grant the other requester becomes the preferred one
  assign ptr_next = grant_valid ? ~grant_idx : ptr;
`else
  logic unused_ptr;

  assign unused_ptr = ptr;
  assign grant_idx  = ~claim[0];
  assign ptr_next   = 1'b0;
`endif

endmodule

// File: rtl/picorv32_div_arbiter.sv
// rtl/picorv32_div_arbiter.sv - shares one PCPI divider between two requesters
// Selection policy set by PICORV32_DIV_ARB_RR_EN (round-robin) inside picorv32_div_arb_pick.
module picorv32_div_arbiter
  import picorv32_div_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,

  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        req0_wr,
  output logic [31:0] req0_rd,
  output logic        req0_wait,
  output logic        req0_ready,

  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        req1_wr,
  output logic [31:0] req1_rd,
  output logic        req1_wait,
  output logic        req1_ready,

  output logic        div_valid,
  output logic [31:0] div_insn,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready
);

  state_t state_q, state_next;

  logic [NUM_REQ-1:0] claim;
  logic [NUM_REQ-1:0] pick_claim;
  logic [NUM_REQ-1:0] served_mask;
  logic [NUM_REQ-1:0] done_mask;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] wait_q;

  logic        pick_valid;
  logic        pick_idx;
  logic        ptr_q;
  logic        ptr_next;
  logic        grant_q;
  logic        abort_q;
  logic        res_wr_q;
  logic [31:0] hold_insn;
  logic [31:0] hold_rs1;
  logic [31:0] hold_rs2;
  logic [31:0] res_q;

  logic        do_grant;
  logic        complete;
  logic        deliver;
  logic        grantee_valid;

  // Divider's busy indication is only an observation point here
  logic        unused_div_wait;
  assign unused_div_wait = div_wait;

  assign claim = {req1_valid && is_divrem(req1_insn),
                  req0_valid && is_divrem(req0_insn)};

  // The requester just served still holds valid during its ready cycle, so DRAIN masks it
  assign served_mask   = grant_q ? 2'b10 : 2'b01;
  assign pick_claim    = (state_q == ST_DRAIN) ? (claim & ~served_mask) : claim;
  assign grantee_valid = grant_q ? req1_valid : req0_valid;

  picorv32_div_arb_pick u_pick (
    .claim       (pick_claim),
    .ptr         (ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx),
    .ptr_next    (ptr_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    div_valid  = 1'b0;
    do_grant   = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        div_valid = 1'b1;
        if (div_ready) begin
          complete   = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign deliver   = complete && !abort_q && grantee_valid;
  assign done_mask = deliver ? served_mask : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_q   <= 1'b0;
      ptr_q     <= 1'b0;
      abort_q   <= 1'b0;
      hold_insn <= '0;
      hold_rs1  <= '0;
      hold_rs2  <= '0;
      res_q     <= '0;
      res_wr_q  <= 1'b0;
      ready_q   <= '0;
      wait_q    <= '0;
    end else begin
      if (do_grant) begin
        grant_q   <= pick_idx;
        ptr_q     <= ptr_next;
        hold_insn <= pick_idx ? req1_insn : req0_insn;
        hold_rs1  <= pick_idx ? req1_rs1  : req0_rs1;
        hold_rs2  <= pick_idx ? req1_rs2  : req0_rs2;
      end

      // A grantee that drops valid mid-operation forfeits the result
      if (do_grant)                                   abort_q <= 1'b0;
      else if (state_q == ST_BUSY && !grantee_valid) abort_q <= 1'b1;

      if (complete) begin
        res_q    <= div_rd;
        res_wr_q <= div_wr;
      end

      ready_q <= done_mask;
      wait_q  <= claim & ~done_mask & ~ready_q;
    end
  end

  assign div_insn = hold_insn;
  assign div_rs1  = hold_rs1;
  assign div_rs2  = hold_rs2;

  assign req0_ready = ready_q[0];
  assign req0_wr    = ready_q[0] & res_wr_q;
  assign req0_rd    = ready_q[0] ? res_q : '0;
  assign req0_wait  = wait_q[0];

  assign req1_ready = ready_q[1];
  assign req1_wr    = ready_q[1] & res_wr_q;
  assign req1_rd    = ready_q[1] ? res_q : '0;
  assign req1_wait  = wait_q[1];

endmodule
